// File: rtl/uat_baud_pkg.sv
// Shared definitions for the UART baud scheduler: rate table, divisor helper, FSM states.
package uat_baud_pkg;

    localparam int BAUD_SEL_W = 3;
    localparam int NUM_RATES  = 1 << BAUD_SEL_W;

    localparam int unsigned BAUD_TABLE [NUM_RATES] = '{
        9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND
    } baud_state_t;

    // Rounded system-clock cycles per oversample tick.
    function automatic longint unsigned f_baud_div(
        input longint unsigned freq,
        input longint unsigned baud,
        input longint unsigned os
    );
        longint unsigned den;
        den = baud * os;
        return (freq + den / 2) / den;
    endfunction

endpackage

// File: rtl/baud_os_counter.sv
// Loadable oversample down-counter with a wrapping tick index.
module baud_os_counter #(
    parameter int unsigned OS    = 16,
    parameter int          IDX_W = $clog2(OS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [15:0]      load_val,
    input  logic             en,
    output logic             tick,
    output logic [IDX_W-1:0] idx
);

    logic [15:0] cnt;

    assign tick = en && (cnt == '0);

    // load wins over a wrap so a rate switch on the boundary tick restarts cleanly
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (load) begin
            cnt <= load_val;
            idx <= '0;
        end else if (tick) begin
            cnt <= load_val;
            idx <= idx + 1'b1;
        end else if (en) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/baud_sched.sv
// Baud timing controller: oversample/bit/mid-bit tick enables with a runtime-selectable rate
// that switches only on bit boundaries.
module baud_sched
    import uat_baud_pkg::*;
#(
    parameter int unsigned            p_input_freq  = 50_000_000,
    parameter int unsigned            p_oversample  = 16,
    parameter logic [BAUD_SEL_W-1:0]  p_default_sel = 3'd4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [BAUD_SEL_W-1:0] i_sel,
    input  logic                  i_sel_valid,
    output logic                  o_sel_ready,
    input  logic                  i_rx_sync,
    output logic                  o_os_tick,
    output logic                  o_bit_tick,
    output logic                  o_mid_tick,
    output logic [BAUD_SEL_W-1:0] o_active_sel,
    output logic                  o_busy
);

    localparam int IDX_W = $clog2(p_oversample);

    if (p_oversample < 4 || (p_oversample & (p_oversample - 1)) != 0) begin : g_bad_os
        $error("baud_sched: p_oversample must be a power of 2 and at least 4");
    end

    logic [15:0] div_tab [NUM_RATES];

    for (genvar g = 0; g < NUM_RATES; g++) begin : g_div
        localparam longint unsigned DIV = f_baud_div(p_input_freq, BAUD_TABLE[g], p_oversample);
        if (DIV < 2 || DIV > 65535) begin : g_bad_div
            $error("baud_sched: divisor for table entry %0d is out of range", g);
        end
        assign div_tab[g] = 16'(DIV);
    end

    baud_state_t           state;
    logic [BAUD_SEL_W-1:0] pend_sel;
    logic [BAUD_SEL_W-1:0] sel_next;
    logic                  accept;
    logic                  counting;
    logic                  sync;
    logic                  boundary;
    logic                  load;
    logic                  tick;
    logic [IDX_W-1:0]      idx;

    assign counting = (state != IDLE);
    assign sync     = counting && i_rx_sync;
    assign accept   = i_sel_valid && o_sel_ready;

    assign o_os_tick  = tick;
    assign o_bit_tick = tick && (idx == IDX_W'(p_oversample - 1));
    assign o_mid_tick = tick && (idx == IDX_W'(p_oversample / 2 - 1));
    assign boundary   = (state == PEND) && o_bit_tick;

    // sel_next is the index the counters should run on from the next cycle onward
    always_comb begin
        sel_next = o_active_sel;
        if (state == PEND) begin
            if (!i_en || boundary)
                sel_next = pend_sel;
        end else if (accept && (state == IDLE || !i_en)) begin
            sel_next = i_sel;
        end
    end

    assign load = !i_en || (state == IDLE) || sync || boundary;

    baud_os_counter #(
        .OS    (p_oversample),
        .IDX_W (IDX_W)
    ) u_os_counter (
        .clk      (i_clk),
        .rst      (i_rst),
        .load     (load),
        .load_val (div_tab[sel_next] - 16'd1),
        .en       (counting && !i_rx_sync),
        .tick     (tick),
        .idx      (idx)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            o_active_sel <= p_default_sel;
            pend_sel     <= p_default_sel;
            o_sel_ready  <= 1'b1;
            o_busy       <= 1'b0;
        end else begin
            o_active_sel <= sel_next;
            if (!i_en) begin
                state       <= IDLE;
                o_sel_ready <= 1'b1;
                o_busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state  <= RUN;
                        o_busy <= 1'b1;
                    end
                    RUN: begin
                        if (accept) begin
                            pend_sel    <= i_sel;
                            state       <= PEND;
                            o_sel_ready <= 1'b0;
                        end
                    end
                    PEND: begin
                        if (boundary) begin
                            state       <= RUN;
                            o_sel_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        o_sel_ready <= 1'b1;
                        o_busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
